// File: rtl/pito_uart_mmio.sv
// Memory-mapped 8N1 UART for the pito data port: DATA/STATUS/DIV/CTRL window,
// TX/RX byte FIFOs, runtime baud divisor, sticky error flags and a level interrupt.

module pito_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module pito_uart_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter int          DIV_WIDTH   = 16,
  parameter int          DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus handshake: a request is taken in the single cycle where req && hit is high;
  // the peripheral is always ready, and read data appears on rdata the next cycle.
  logic       acc, wr, rd;
  logic [1:0] sel;
  assign hit = (addr[31:4] == BASE_ADDR[31:4]);
  assign acc = req && hit;
  assign wr  = acc && we;
  assign rd  = acc && !we;
  assign sel = addr[3:2];

  logic addr_unused;
  assign addr_unused = ^addr[1:0];

  logic [DIV_WIDTH-1:0] div, eff_div;
  logic [3:0]           ctrl;
  logic                 tx_en, rx_en;
  logic                 rx_overrun, frame_err, tx_overflow;
  assign tx_en   = ctrl[0];
  assign rx_en   = ctrl[1];
  assign eff_div = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;

  logic flush, tx_push, tx_pop, rx_push, rx_pop, status_rd;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_dout, rx_dout;
  assign flush     = wr && (sel == 2'd3) && be[0] && wdata[4];
  assign tx_push   = wr && (sel == 2'd0) && be[0];
  assign rx_pop    = rd && (sel == 2'd0);
  assign status_rd = rd && (sel == 2'd1);

  // ---------------- TX path ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [7:0]           tx_sh, tx_sh_n;
  logic                 tx_last, tx_busy;
  assign tx_last = (tx_cnt == tx_div - 1'b1);
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        // Divisor is latched here so a DIV write only affects the next frame.
        if (tx_en && !tx_empty && !flush) begin
          tx_pop     = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_sh_n    = tx_dout;
          tx_div_n   = eff_div;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else tx_bit_n = tx_bit + 1'b1;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_STOP: begin
        if (tx_last) tx_state_n = TX_IDLE;
        else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (tx_state == TX_START) tx = 1'b0;
    else if (tx_state == TX_DATA) tx = tx_sh[0];
  end

  pito_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(tx_push), .din(wdata[7:0]),
    .pop(tx_pop), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  // ---------------- RX path ----------------
  logic rx_s1, rx_s2, rx_s3;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  rx_state_t            rx_state, rx_state_n;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n, rx_half;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [7:0]           rx_sh, rx_sh_n;
  logic                 rx_wait, rx_wait_n, rx_last;
  logic                 overrun_set, frame_set;
  assign rx_half = rx_div >> 1;
  assign rx_last = (rx_cnt == rx_div - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_wait  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_wait  <= rx_wait_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_wait_n   = rx_wait;
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    frame_set   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_en && rx_s3 && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
          rx_div_n   = eff_div;
        end
      end
      RX_START: begin
        // Mid-bit check of the start bit; a high line here was only a glitch.
        if (rx_cnt == rx_half - 1'b1) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: begin
        if (rx_wait) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
            rx_wait_n  = 1'b0;
          end
        end else if (rx_last) begin
          if (rx_s2) begin
            rx_push     = 1'b1;
            overrun_set = rx_full;
            rx_state_n  = RX_IDLE;
          end else begin
            frame_set = 1'b1;
            rx_wait_n = 1'b1;
          end
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  pito_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // ---------------- Registers and read port ----------------
  logic [7:0]  status;
  logic [31:0] rd_word, div_cur32, div_wr32;
  logic        div_unused;
  assign status = {tx_overflow, frame_err, tx_busy, rx_overrun,
                   rx_full, rx_empty, tx_empty, tx_full};
  assign div_cur32  = 32'(div);
  assign div_unused = ^div_wr32;

  always_comb begin
    for (int i = 0; i < 4; i++)
      div_wr32[8*i +: 8] = be[i] ? wdata[8*i +: 8] : div_cur32[8*i +: 8];
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      2'd0:    rd_word = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_dout};
      2'd1:    rd_word = {24'b0, status};
      2'd2:    rd_word = div_cur32;
      default: rd_word = {28'b0, ctrl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      irq         <= 1'b0;
      div         <= DIV_WIDTH'(DEFAULT_DIV);
      ctrl        <= 4'b0011;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rdata <= rd ? rd_word : 32'h0;
      irq   <= (ctrl[2] && !rx_empty) || (ctrl[3] && tx_empty && !tx_busy);
      if (wr && sel == 2'd2) div <= div_wr32[DIV_WIDTH-1:0];
      if (wr && sel == 2'd3 && be[0]) ctrl <= wdata[3:0];
      // A set in the same cycle as the clearing STATUS read wins.
      rx_overrun  <= (rx_overrun  && !status_rd) || overrun_set;
      frame_err   <= (frame_err   && !status_rd) || frame_set;
      tx_overflow <= (tx_overflow && !status_rd) || (tx_push && tx_full);
    end
  end
endmodule

// File: tb/tb_pito_uart_mmio.sv
// Directed bench for pito_uart_mmio: register window, TX framing, FIFO limits,
// RX reception and error flags, interrupt, flush, divisor clamp and mid-frame reset.

module tb_pito_uart_mmio;
  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_DIV  = 32'h8000_0008;
  localparam logic [31:0] A_CTRL = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst, req, we, hit, tx, rx, irq;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  pito_uart_mmio dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .hit(hit), .tx(tx), .rx(rx), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Decodes DIV=4 frames off tx, sampling each bit in its middle.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = tx;
        end
        repeat (4) @(negedge clk);
        if (tx === 1'b1) got_q.push_back(b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 4'hF;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(negedge clk);
    d = rdata;
    req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) rx = b[k];
      repeat (3) @(negedge clk);
    end
    @(negedge clk) rx = stop_bit;
    repeat (3) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b exp 1", tx); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    n_checks++;
    addr = A_STAT; #1;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_in: got %b exp 1", hit); end
    n_checks++;
    addr = 32'h8000_0010; #1;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_out: got %b exp 0", hit); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h06) begin n_fail++; $display("FAIL reset_status: got %h exp 06", d); end
    n_checks++;
    @(negedge clk);
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_idle: got %h exp 0", rdata); end
    n_checks++;
    bus_read(A_CTRL, d);
    if (d !== 32'h3) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 3", d); end
    n_checks++;
    bus_read(A_DIV, d);
    if (d !== 32'd868) begin n_fail++; $display("FAIL reset_div: got %0d exp 868", d); end
    n_checks++;
    bus_write(32'h9000_0008, 32'd5);
    bus_read(A_DIV, d);
    if (d !== 32'd868) begin n_fail++; $display("FAIL nohit_write: got %0d exp 868", d); end
    n_checks++;
    bus_read(32'h8000_0014, d);
    if (d !== 32'h0) begin n_fail++; $display("FAIL nohit_read: got %h exp 0", d); end
    n_checks++;
  endtask

  task automatic test_tx_frame();
    logic [31:0] d;
    logic [7:0]  b;
    logic        e;
    int          lat;
    b = 8'h55;
    bus_write(A_DIV, 32'd4);
    bus_read(A_DIV, d);
    if (d !== 32'd4) begin n_fail++; $display("FAIL div_rw: got %0d exp 4", d); end
    n_checks++;
    bus_write(A_DATA, {24'h0, b});
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin @(negedge clk); lat++; end
    if (lat !== 1) begin n_fail++; $display("FAIL tx_start_latency: got %0d exp 1", lat); end
    n_checks++;
    for (int i = 0; i < 42; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 36) e = 1'b1;
      else if (i < 4) e = 1'b0;
      else e = b[(i - 4) / 4];
      if (tx !== e) begin n_fail++; $display("FAIL tx_bit[%0d]: got %b exp %b", i, tx, e); end
      n_checks++;
      if (i == 39) begin req = 1'b1; we = 1'b0; addr = A_STAT; end
      if (i == 40) begin
        if (rdata[5] !== 1'b1) begin n_fail++; $display("FAIL busy_last: got %b exp 1", rdata[5]); end
        n_checks++;
      end
      if (i == 41) begin
        if (rdata[5] !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %b exp 0", rdata[5]); end
        n_checks++;
        req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  v, g;
    int          t;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      v = 8'h21 + 8'(i * 37);
      bus_write(A_DATA, {24'h0, v});
      exp_q.push_back(v);
    end
    bus_read(A_STAT, d);
    if (d !== 32'h25) begin n_fail++; $display("FAIL b2b_full: got %h exp 25", d); end
    n_checks++;
    bus_write(A_DATA, 32'hEE);
    bus_read(A_STAT, d);
    if (d !== 32'hA5) begin n_fail++; $display("FAIL b2b_overflow: got %h exp a5", d); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h25) begin n_fail++; $display("FAIL b2b_ovf_clear: got %h exp 25", d); end
    n_checks++;
    t = 0;
    while (got_q.size() < 17 && t < 1200) begin @(negedge clk); t++; end
    if (got_q.size() !== 17) begin n_fail++; $display("FAIL b2b_count: got %0d exp 17", got_q.size()); end
    n_checks++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      v = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== v) begin n_fail++; $display("FAIL b2b_byte: got %h exp %h", g, v); end
      n_checks++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rx_frame();
    logic [31:0] d;
    send_rx(8'hA3, 1'b1);
    bus_read(A_STAT, d);
    if (d !== 32'h02) begin n_fail++; $display("FAIL rx_status: got %h exp 02", d); end
    n_checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h1A3) begin n_fail++; $display("FAIL rx_data: got %h exp 1a3", d); end
    n_checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h exp 0", d); end
    n_checks++;
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  v;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      v = 8'h40 + 8'(i * 5);
      send_rx(v, 1'b1);
      if (i < 16) exp_q.push_back(v);
    end
    bus_read(A_STAT, d);
    if (d !== 32'h1A) begin n_fail++; $display("FAIL ovr_status: got %h exp 1a", d); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h0A) begin n_fail++; $display("FAIL ovr_clear: got %h exp 0a", d); end
    n_checks++;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      bus_read(A_DATA, d);
      if (d !== {23'h0, 1'b1, v}) begin n_fail++; $display("FAIL ovr_data: got %h exp %h", d, {23'h0, 1'b1, v}); end
      n_checks++;
    end
    bus_read(A_DATA, d);
    if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_drained: got %h exp 0", d); end
    n_checks++;
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    send_rx(8'h5C, 1'b0);
    bus_read(A_STAT, d);
    if (d !== 32'h46) begin n_fail++; $display("FAIL ferr_status: got %h exp 46", d); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h06) begin n_fail++; $display("FAIL ferr_clear: got %h exp 06", d); end
    n_checks++;
    send_rx(8'h3C, 1'b1);
    bus_read(A_DATA, d);
    if (d !== 32'h13C) begin n_fail++; $display("FAIL ferr_recover: got %h exp 13c", d); end
    n_checks++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_STAT, d);
    if (d !== 32'h06) begin n_fail++; $display("FAIL glitch_status: got %h exp 06", d); end
    n_checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_data: got %h exp 0", d); end
    n_checks++;
  endtask

  task automatic test_irq_flush();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h7);
    @(negedge clk);
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b exp 0", irq); end
    n_checks++;
    send_rx(8'h96, 1'b1);
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx: got %b exp 1", irq); end
    n_checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h196) begin n_fail++; $display("FAIL irq_data: got %h exp 196", d); end
    n_checks++;
    @(negedge clk);
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", irq); end
    n_checks++;
    bus_write(A_CTRL, 32'hB);
    repeat (2) @(negedge clk);
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_txe: got %b exp 1", irq); end
    n_checks++;
    bus_read(A_CTRL, d);
    if (d !== 32'hB) begin n_fail++; $display("FAIL ctrl_rw: got %h exp b", d); end
    n_checks++;
    bus_write(A_CTRL, 32'h2);
    bus_write(A_DATA, 32'h11);
    bus_write(A_DATA, 32'h22);
    bus_read(A_STAT, d);
    if (d !== 32'h04) begin n_fail++; $display("FAIL txdis_status: got %h exp 04", d); end
    n_checks++;
    bus_write(A_CTRL, 32'h12);
    bus_read(A_CTRL, d);
    if (d !== 32'h2) begin n_fail++; $display("FAIL flush_ctrl: got %h exp 2", d); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h06) begin n_fail++; $display("FAIL flush_status: got %h exp 06", d); end
    n_checks++;
    bus_write(A_CTRL, 32'h3);
    repeat (10) @(negedge clk);
    if (tx !== 1'b1) begin n_fail++; $display("FAIL flush_tx_idle: got %b exp 1", tx); end
    n_checks++;
  endtask

  task automatic test_div_min();
    logic [31:0] d;
    int          t, lows;
    bus_write(A_DIV, 32'd1);
    bus_read(A_DIV, d);
    if (d !== 32'd1) begin n_fail++; $display("FAIL div1_read: got %0d exp 1", d); end
    n_checks++;
    bus_write(A_DATA, 32'h00);
    t = 0;
    while (tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    lows = 0;
    while (tx === 1'b0 && lows < 100) begin lows++; @(negedge clk); end
    if (lows !== 18) begin n_fail++; $display("FAIL div1_low_cycles: got %0d exp 18", lows); end
    n_checks++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    bus_write(A_DIV, 32'd4);
    bus_write(A_DATA, 32'h00);
    repeat (8) @(negedge clk);
    if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_low: got %b exp 0", tx); end
    n_checks++;
    rst = 1'b1;
    @(negedge clk);
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_tx: got %b exp 1", tx); end
    n_checks++;
    rst = 1'b0;
    bus_read(A_DIV, d);
    if (d !== 32'd868) begin n_fail++; $display("FAIL midframe_div: got %0d exp 868", d); end
    n_checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h06) begin n_fail++; $display("FAIL midframe_status: got %h exp 06", d); end
    n_checks++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx_frame();
    test_rx_overrun();
    test_frame_err();
    test_glitch();
    test_irq_flush();
    test_div_min();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pito_uart_mmio.md
Name: pito_uart_mmio

Overview:
Memory-mapped 8N1 UART peripheral for the pito SoC data-memory port. Replaces the fixed single-address, write-only UART hookup with a 4-register window carrying a runtime baud divisor, parametrised TX/RX FIFOs, RX readback, sticky error flags and an interrupt output. Sits beside d_mem on the core's local data port; the SoC routes a request here when the `hit` output is high.

Parameters:
BASE_ADDR, 32'h8000_0000, byte base address of the 16-byte register window
TX_DEPTH, 16, TX FIFO entries (power of two, >=2)
RX_DEPTH, 16, RX FIFO entries (power of two, >=2)
DIV_WIDTH, 16, baud divisor register width
DEFAULT_DIV, 868, reset divisor in clk cycles per bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  1  bus request
we  in  1  write enable (1=write, 0=read)
addr  in  32  byte address
wdata  in  32  write data
be  in  4  byte enables
rdata  out  32  read data, valid one cycle after a read request
hit  out  1  combinational: addr[31:4]==BASE_ADDR[31:4]
tx  out  1  serial output, idles high
rx  in  1  serial input, asynchronous
irq  out  1  registered interrupt

Behaviour:
- Reset: tx=1, rdata=0, irq=0, both FIFOs empty, all sticky flags 0, DIV=DEFAULT_DIV, CTRL=4'b0011, TX and RX FSMs in IDLE. A reset mid-frame aborts the frame; tx returns high on the next cycle.
- An access is effective only when req&hit. Non-hit accesses have no side effects.
- Register select is addr[3:2].
  - 0 DATA. Write with be[0] pushes wdata[7:0] to TX. Read pops RX and returns {23'b0, valid, byte}; valid=0 and no pop when RX is empty.
  - 1 STATUS (read-only): b0 tx_full, b1 tx_empty, b2 rx_empty, b3 rx_full, b4 rx_overrun, b5 tx_busy, b6 frame_err, b7 tx_overflow. b4, b6 and b7 are sticky and clear on a STATUS read; a set event in the same cycle as the read wins.
  - 2 DIV (read/write): bits [DIV_WIDTH-1:0]. A value of 0 or 1 behaves as 2.
  - 3 CTRL: b0 tx_en, b1 rx_en, b2 rx_irq_en, b3 txe_irq_en. Writing b4=1 flushes both FIFOs this cycle. b4 is write-only and reads 0.
- Read latency: exactly 1 cycle, registered. rdata=0 in any cycle not following an effective read.
- TX overflow: a DATA write while TX is full drops the byte and sets tx_overflow.
- Each FIFO supports simultaneous push and pop: count unchanged, data order preserved. Pointers wrap modulo depth. Full and empty are derived from a count of width clog2(depth)+1.
- TX FSM: IDLE->START->DATA->STOP->IDLE.
  - Leaves IDLE when tx_en & !tx_empty. Pops the byte and latches DIV at that moment; a DIV write mid-frame affects the next frame only.
  - Each bit is held DIV cycles. Start bit 0, 8 data bits LSB first, stop bit 1.
  - tx_busy=1 outside IDLE.
  - Clearing tx_en mid-frame completes the current frame.
- RX:
  - rx passes through a 2-flop synchroniser.
  - FSM: IDLE->START->DATA->STOP->IDLE.
  - IDLE waits for a synchronised falling edge with rx_en=1. START waits DIV/2 cycles, then samples: low continues to DATA, high is a glitch and returns to IDLE.
  - 8 data bits are sampled every DIV cycles, LSB first, then the stop bit is sampled.
  - Stop=1: push the byte. If RX is full, drop the byte and set rx_overrun.
  - Stop=0: drop the byte, set frame_err, and return to IDLE once rx is seen high.
- irq is registered each cycle as (rx_irq_en & !rx_empty) | (txe_irq_en & tx_empty & !tx_busy).

Test Plan:
- Reset, then read STATUS at 0x8000_0004 -> rdata=0x06 one cycle later; tx=1; read CTRL -> 0x3; read DIV -> 868.
- DIV=4, write 0x55 to DATA -> tx shows 0 for 4 clks, then bits 1,0,1,0,1,0,1,0 of 4 clks each, then 1; STATUS b5 high for exactly 40 clks.
- DIV=4, write 17 bytes back-to-back with TX_DEPTH=16 -> first byte starts immediately and frees one slot; the 17th is accepted, or when written before the first pop it is dropped with STATUS b7=1. All accepted bytes appear on tx in order.
- Drive an rx frame 0xA3 at DIV=4 -> STATUS b2=0; DATA read returns 0x1A3; next DATA read returns 0x000.
- Receive RX_DEPTH+1 frames without reading -> STATUS b3=1, b4=1; a second STATUS read shows b4=0; FIFO holds the first 16 bytes.
- Rx frame with stop bit 0 -> b6=1, no push. A 1-clk low glitch on rx -> no push, no flags. Set rx_irq_en, receive one byte -> irq=1 until a DATA read empties RX.
